// File: rtl/tt_um_jimktrains_vslc_fetch_if.sv
// Bus between the EEPROM reader / program executor and the VSLC fetch unit.
// The master side is the reader plus executor; the slave side is the fetch unit.
interface tt_um_jimktrains_vslc_fetch_if;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [15:0] rd_addr;
    logic        rd_hold_n;
    logic        restart;
    logic [15:0] start_addr;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        scan_start;
    logic        hdr_err;
    logic        overflow;

    modport master (
        output rd_valid, rd_data, rd_addr, instr_ready,
        input  rd_hold_n, restart, start_addr, instr, instr_valid,
               scan_start, hdr_err, overflow
    );

    modport slave (
        input  rd_valid, rd_data, rd_addr, instr_ready,
        output rd_hold_n, restart, start_addr, instr, instr_valid,
               scan_start, hdr_err, overflow
    );
endinterface

// File: rtl/tt_um_jimktrains_vslc_fetch.sv
// VSLC program fetch: parses the 4-byte EEPROM header, then streams the program
// bytes between start and end through a small FIFO to the executor, once per scan.
module tt_um_jimktrains_vslc_fetch #(
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    tt_um_jimktrains_vslc_fetch_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] HOLD_C  = (PTR_W + 1)'(FIFO_DEPTH - 1);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two between 2 and 16");
    end

    typedef enum logic [2:0] {S_HDR, S_RUN, S_DRAIN, S_RESTART, S_ERR} state_t;

    state_t              state_q;
    logic [9:0]          start_q, end_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;
    logic                restart_q, scan_q, hdr_err_q, ovf_q, hold_n_q;

    logic                full, pop, in_range, push_req, push_ok, ovf_set, hdr_bad;
    logic [9:0]          end_new;

    always_comb begin
        full     = (count_q == DEPTH_C);
        pop      = (count_q != '0) && bus.instr_ready;
        in_range = ({6'b0, start_q} <= bus.rd_addr) && (bus.rd_addr <= {6'b0, end_q});
        push_req = bus.rd_valid && (state_q == S_RUN) && in_range;
        // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
        push_ok  = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;
        end_new  = {end_q[9:8], bus.rd_data};
        hdr_bad  = (end_new == '0) || (start_q < 10'd4) || (end_new < start_q);
        count_d  = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            start_q   <= '0;
            end_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            restart_q <= 1'b0;
            scan_q    <= 1'b0;
            hdr_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            hold_n_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ovf_set) ovf_q    <= 1'b1;
            count_q   <= count_d;
            // One slot of margin covers the byte already in flight from the reader.
            hold_n_q  <= (count_d < HOLD_C);
            restart_q <= 1'b0;
            scan_q    <= 1'b0;
            unique case (state_q)
                S_HDR: begin
                    if (bus.rd_valid) begin
                        unique case (bus.rd_addr)
                            16'd0: start_q[9:8] <= bus.rd_data[1:0];
                            16'd1: start_q[7:0] <= bus.rd_data;
                            16'd2: end_q[9:8]   <= bus.rd_data[1:0];
                            16'd3: begin
                                end_q[7:0] <= bus.rd_data;
                                if (hdr_bad) begin
                                    state_q   <= S_ERR;
                                    hdr_err_q <= 1'b1;
                                end else begin
                                    state_q <= S_RUN;
                                    scan_q  <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (push_req && (bus.rd_addr == {6'b0, end_q})) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (count_d == '0) begin
                        state_q   <= S_RESTART;
                        restart_q <= 1'b1;
                        scan_q    <= 1'b1;
                    end
                end
                S_RESTART: state_q <= S_RUN;
                S_ERR:     state_q <= S_ERR;
                default:   state_q <= S_HDR;
            endcase
        end
    end

    // Program bytes are pure data; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.rd_data;
    end

    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.rd_hold_n   = hold_n_q;
    assign bus.restart     = restart_q;
    assign bus.scan_start  = scan_q;
    assign bus.start_addr  = {6'b0, start_q};
    assign bus.hdr_err     = hdr_err_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_tt_um_jimktrains_vslc_fetch.sv
// Directed bench for the VSLC fetch unit: header parsing, range filtering,
// FIFO hold/overflow/wrap behaviour, header errors and reset during drain.
module tb_tt_um_jimktrains_vslc_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    tt_um_jimktrains_vslc_fetch_if bus ();

    tt_um_jimktrains_vslc_fetch #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] a, input logic [7:0] d);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        bus.rd_data  = d;
        cyc();
        bus.rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.rd_valid    = 1'b0;
        bus.instr_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic hdr(input logic [7:0] b0, b1, b2, b3);
        put(16'd0, b0);
        put(16'd1, b1);
        put(16'd2, b2);
        put(16'd3, b3);
    endtask

    task automatic test_reset();
        bus.rd_valid = 1'b0; bus.rd_data = '0; bus.rd_addr = '0; bus.instr_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_instr_valid: got %b want 0", bus.instr_valid); end
        tests_run++; if (bus.instr !== 8'h00) begin tests_failed++; $display("FAIL rst_instr: got %h want 00", bus.instr); end
        tests_run++; if (bus.rd_hold_n !== 1'b1) begin tests_failed++; $display("FAIL rst_hold_n: got %b want 1", bus.rd_hold_n); end
        tests_run++; if ({bus.restart, bus.scan_start, bus.hdr_err, bus.overflow} !== 4'b0000) begin tests_failed++; $display("FAIL rst_flags: got %b want 0000", {bus.restart, bus.scan_start, bus.hdr_err, bus.overflow}); end
        tests_run++; if (bus.start_addr !== 16'h0000) begin tests_failed++; $display("FAIL rst_start_addr: got %h want 0000", bus.start_addr); end
        cyc();
        rst_n = 1'b1;
        cyc();
        tests_run++; if (bus.scan_start !== 1'b0 || bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_after_release: got scan=%b valid=%b want 0 0", bus.scan_start, bus.instr_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b;
        do_reset();
        bus.instr_ready = 1'b1;
        put(16'd0, 8'h00); put(16'd1, 8'h04); put(16'd2, 8'h00);
        tests_run++; if (bus.scan_start !== 1'b0) begin tests_failed++; $display("FAIL basic_scan_early: got %b want 0", bus.scan_start); end
        put(16'd3, 8'h07);
        tests_run++; if (bus.scan_start !== 1'b1) begin tests_failed++; $display("FAIL basic_scan: got %b want 1", bus.scan_start); end
        tests_run++; if (bus.start_addr !== 16'h0004) begin tests_failed++; $display("FAIL basic_start_addr: got %h want 0004", bus.start_addr); end
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'hA0 + 8'(i);
            put(16'(4 + i), exp_b);
            tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_b) begin tests_failed++; $display("FAIL basic_instr%0d: got v=%b %h want v=1 %h", i, bus.instr_valid, bus.instr, exp_b); end
            tests_run++; if (bus.scan_start !== 1'b0 || bus.restart !== 1'b0) begin tests_failed++; $display("FAIL basic_no_pulse%0d: got scan=%b restart=%b want 0 0", i, bus.scan_start, bus.restart); end
        end
        cyc();
        tests_run++; if (bus.restart !== 1'b1 || bus.scan_start !== 1'b1) begin tests_failed++; $display("FAIL basic_restart: got restart=%b scan=%b want 1 1", bus.restart, bus.scan_start); end
        tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_empty: got %b want 0", bus.instr_valid); end
        cyc();
        tests_run++; if (bus.restart !== 1'b0 || bus.scan_start !== 1'b0) begin tests_failed++; $display("FAIL basic_restart_once: got restart=%b scan=%b want 0 0", bus.restart, bus.scan_start); end
        tests_run++; if (bus.start_addr !== 16'h0004) begin tests_failed++; $display("FAIL basic_start_stable: got %h want 0004", bus.start_addr); end
    endtask

    task automatic test_range();
        logic [7:0] exp_b;
        do_reset();
        hdr(8'h00, 8'h06, 8'h00, 8'h09);
        for (int a = 4; a <= 9; a++) put(16'(a), 8'(8'h40 + a));
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'h46 + 8'(i);
            tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_b) begin tests_failed++; $display("FAIL range_instr%0d: got v=%b %h want v=1 %h", i, bus.instr_valid, bus.instr, exp_b); end
            cyc();
        end
        tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL range_empty: got %b want 0", bus.instr_valid); end
        tests_run++; if (bus.restart !== 1'b1) begin tests_failed++; $display("FAIL range_restart: got %b want 1", bus.restart); end
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL range_overflow: got %b want 0", bus.overflow); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        do_reset();
        hdr(8'h00, 8'h04, 8'h00, 8'h0F);
        put(16'd4, 8'hB0);
        put(16'd5, 8'hB1);
        tests_run++; if (bus.rd_hold_n !== 1'b1) begin tests_failed++; $display("FAIL ovf_hold_cnt2: got %b want 1", bus.rd_hold_n); end
        put(16'd6, 8'hB2);
        tests_run++; if (bus.rd_hold_n !== 1'b0) begin tests_failed++; $display("FAIL ovf_hold_cnt3: got %b want 0", bus.rd_hold_n); end
        put(16'd7, 8'hB3);
        tests_run++; if (bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_4th_stored: got %b want 0", bus.overflow); end
        put(16'd8, 8'hB4);
        tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_5th_dropped: got %b want 1", bus.overflow); end
        cyc();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'hB0 + 8'(i);
            tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_b) begin tests_failed++; $display("FAIL ovf_instr%0d: got v=%b %h want v=1 %h", i, bus.instr_valid, bus.instr, exp_b); end
            cyc();
        end
        tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty: got %b want 0", bus.instr_valid); end
        tests_run++; if (bus.overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        tests_run++; if (bus.rd_hold_n !== 1'b1 || bus.restart !== 1'b0) begin tests_failed++; $display("FAIL ovf_after: got hold=%b restart=%b want 1 0", bus.rd_hold_n, bus.restart); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        do_reset();
        hdr(8'h00, 8'h04, 8'h00, 8'h0F);
        for (int i = 0; i < 4; i++) put(16'(4 + i), 8'hC0 + 8'(i));
        bus.instr_ready = 1'b1;
        put(16'd8, 8'hC4);
        tests_run++; if (bus.instr !== 8'hC1) begin tests_failed++; $display("FAIL b2b_head1: got %h want c1", bus.instr); end
        tests_run++; if (bus.rd_hold_n !== 1'b0 || bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_full: got hold=%b ovf=%b want 0 0", bus.rd_hold_n, bus.overflow); end
        put(16'd9, 8'hC5);
        for (int i = 0; i < 4; i++) begin
            exp_b = 8'hC2 + 8'(i);
            tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_b) begin tests_failed++; $display("FAIL b2b_instr%0d: got v=%b %h want v=1 %h", i, bus.instr_valid, bus.instr, exp_b); end
            cyc();
        end
        tests_run++; if (bus.instr_valid !== 1'b0 || bus.overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got v=%b ovf=%b want 0 0", bus.instr_valid, bus.overflow); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_hdr_err();
        do_reset();
        bus.instr_ready = 1'b1;
        hdr(8'h00, 8'h04, 8'h00, 8'h00);
        tests_run++; if (bus.hdr_err !== 1'b1 || bus.scan_start !== 1'b0) begin tests_failed++; $display("FAIL err_flag: got err=%b scan=%b want 1 0", bus.hdr_err, bus.scan_start); end
        put(16'd4, 8'hD0);
        put(16'd5, 8'hD1);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (bus.instr_valid !== 1'b0 || bus.restart !== 1'b0 || bus.scan_start !== 1'b0) begin tests_failed++; $display("FAIL err_quiet%0d: got v=%b rs=%b sc=%b want 0 0 0", i, bus.instr_valid, bus.restart, bus.scan_start); end
            tests_run++; if (bus.hdr_err !== 1'b1 || bus.rd_hold_n !== 1'b1) begin tests_failed++; $display("FAIL err_sticky%0d: got err=%b hold=%b want 1 1", i, bus.hdr_err, bus.rd_hold_n); end
            cyc();
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_reset_drain();
        do_reset();
        hdr(8'h00, 8'h04, 8'h00, 8'h05);
        put(16'd4, 8'hE0);
        put(16'd5, 8'hE1);
        tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr !== 8'hE0) begin tests_failed++; $display("FAIL rd_queued: got v=%b %h want v=1 e0", bus.instr_valid, bus.instr); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (bus.instr_valid !== 1'b0 || bus.instr !== 8'h00) begin tests_failed++; $display("FAIL rd_async: got v=%b %h want v=0 00", bus.instr_valid, bus.instr); end
        tests_run++; if (bus.start_addr !== 16'h0000) begin tests_failed++; $display("FAIL rd_start_clr: got %h want 0000", bus.start_addr); end
        cyc();
        #3 rst_n = 1'b1;
        cyc();
        hdr(8'h00, 8'h08, 8'h00, 8'h0A);
        tests_run++; if (bus.scan_start !== 1'b1 || bus.start_addr !== 16'h0008 || bus.hdr_err !== 1'b0) begin tests_failed++; $display("FAIL rd_new_hdr: got scan=%b start=%h err=%b want 1 0008 0", bus.scan_start, bus.start_addr, bus.hdr_err); end
        put(16'd8, 8'hF0);
        tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr !== 8'hF0) begin tests_failed++; $display("FAIL rd_new_byte: got v=%b %h want v=1 f0", bus.instr_valid, bus.instr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
        test_overflow();
        test_back_to_back();
        test_hdr_err();
        test_reset_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
